// File: rtl/pck_inject_gen.sv
// Synthetic traffic source: injects PCK_SIZE-flit packets toward a pattern/random mesh destination.
// Head flit appears 1 cycle after the inject decision; every output holds while flit_ready is low.
module pck_inject_gen #(
    parameter int          NX          = 4,
    parameter int          NY          = 4,
    parameter string       TRAFFIC     = "RANDOM",
    parameter int          MAX_PCK_NUM = 10000,
    parameter int          PCK_SIZE    = 4,
    parameter int          INJ_RATE    = 20,
    parameter logic [15:0] SEED        = 16'hACE1,
    localparam int         Xw          = $clog2(NX),
    localparam int         Yw          = $clog2(NY),
    localparam int         PCK_CNTw    = $clog2(MAX_PCK_NUM + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [Xw-1:0]       current_x,
    input  logic [Yw-1:0]       current_y,
    input  logic                flit_ready,
    output logic                flit_valid,
    output logic                hdr_flg,
    output logic                tail_flg,
    output logic [Xw-1:0]       dest_x,
    output logic [Yw-1:0]       dest_y,
    output logic [PCK_CNTw-1:0] pck_count,
    output logic                done
);
    localparam int PAT = (TRAFFIC == "TRANSPOSE1")     ? 1 :
                         (TRAFFIC == "TRANSPOSE2")     ? 2 :
                         (TRAFFIC == "BIT_COMPLEMENT") ? 3 :
                         (TRAFFIC == "TORNADO")        ? 4 :
                         (TRAFFIC == "NEIGHBOR")       ? 5 : 0;
    localparam bit                  IS_RANDOM = (PAT == 0);
    localparam int                  CNTw      = $clog2(PCK_SIZE);
    localparam logic [CNTw-1:0]     LAST      = CNTw'(PCK_SIZE - 1);
    localparam logic [PCK_CNTw-1:0] MAX_CNT   = PCK_CNTw'(MAX_PCK_NUM);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t              state, state_nxt;
    logic [15:0]         lfsr, seed_mix, lfsr_seed;
    logic [CNTw-1:0]     flit_cnt;
    logic [PCK_CNTw-1:0] pck_inc;
    logic                launch, xfer, tail_xfer;
    logic                inj_ok, fix_ok, dest_ok;
    logic [Xw-1:0]       cand_x, cx_inv;
    logic [Yw-1:0]       cand_y, cy_inv;
    int                  cx, cy, fx, fy, d, own;

    always_comb begin
        seed_mix  = SEED ^ 16'({current_x, current_y});
        lfsr_seed = (seed_mix == 16'h0000) ? 16'h0001 : seed_mix;
    end

    // Fixed patterns are computed in signed int so underflow shows up as out-of-range.
    always_comb begin
        cx     = int'(current_x);
        cy     = int'(current_y);
        cx_inv = ~current_x;
        cy_inv = ~current_y;
        fx     = cx;
        fy     = cy;
        case (PAT)
            1: begin fx = NX - 1 - cy; fy = NY - 1 - cx; end
            2: begin fx = cy; fy = cx; end
            3: begin fx = int'(cx_inv); fy = int'(cy_inv); end
            4: fx = (cx + (NX + 1) / 2 - 1) % NX;
            5: fx = (cx + 1) % NX;
            default: ;
        endcase
        fix_ok = (fx >= 0) && (fx < NX) && (fy >= 0) && (fy < NY) && !((fx == cx) && (fy == cy));

        own    = cy * NX + cx;
        d      = int'(lfsr) % (NX * NY);
        inj_ok = (int'(lfsr) % 100) < INJ_RATE;

        if (IS_RANDOM) begin
            dest_ok = (d != own);
            cand_y  = Yw'(d / NX);
            cand_x  = Xw'(d - (d / NX) * NX);
        end else begin
            dest_ok = fix_ok;
            cand_x  = Xw'(fx);
            cand_y  = Yw'(fy);
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        xfer      = 1'b0;
        tail_xfer = 1'b0;
        pck_inc   = pck_count + 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((pck_count >= MAX_CNT) || (!IS_RANDOM && !fix_ok)) begin
                        state_nxt = DONE;
                    end else if (inj_ok && dest_ok) begin
                        launch    = 1'b1;
                        state_nxt = SEND;
                    end
                end
            end
            SEND: begin
                if (flit_ready) begin
                    xfer = 1'b1;
                    if (flit_cnt == LAST) begin
                        tail_xfer = 1'b1;
                        state_nxt = (pck_inc == MAX_CNT) ? DONE : IDLE;
                    end
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr      <= lfsr_seed;
            flit_cnt  <= '0;
            dest_x    <= '0;
            dest_y    <= '0;
            pck_count <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (launch) begin
                dest_x   <= cand_x;
                dest_y   <= cand_y;
                flit_cnt <= '0;
            end else if (tail_xfer) begin
                flit_cnt <= '0;
            end else if (xfer) begin
                flit_cnt <= flit_cnt + 1'b1;
            end
            if (tail_xfer && (pck_count < MAX_CNT)) pck_count <= pck_inc;
        end
    end

    assign flit_valid = (state == SEND);
    assign hdr_flg    = (state == SEND) && (flit_cnt == '0);
    assign tail_flg   = (state == SEND) && (flit_cnt == LAST);
    assign done       = (state == DONE);
endmodule

// File: tb/tb_pck_inject_gen.sv
// Bench for pck_inject_gen: fixed-pattern, random, backpressure and reset scenarios on four instances.
module tb_pck_inject_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // TRANSPOSE2 instance, 4x4, 3 packets
    logic       t2_start = 1'b0, t2_rdy = 1'b1;
    logic [1:0] t2_x = 2'd1, t2_y = 2'd2;
    logic       t2_vld, t2_hdr, t2_tail, t2_done;
    logic [1:0] t2_dx, t2_dy, t2_cnt;

    // RANDOM instance, 4x4 at (0,0), 1000 packets
    logic       r_start = 1'b0;
    logic       r_vld, r_hdr, r_tail, r_done;
    logic [1:0] r_dx, r_dy;
    logic [9:0] r_cnt;

    // TORNADO / NEIGHBOR instances, 8x4
    logic        to_start = 1'b0, nb_start = 1'b0;
    logic        to_vld, to_hdr, to_tail, to_done, nb_vld, nb_hdr, nb_tail, nb_done;
    logic [2:0]  to_dx, nb_dx;
    logic [1:0]  to_dy, nb_dy;
    logic [13:0] to_cnt, nb_cnt;

    pck_inject_gen #(.NX(4), .NY(4), .TRAFFIC("TRANSPOSE2"), .MAX_PCK_NUM(3), .PCK_SIZE(4), .INJ_RATE(100)) u_t2 (
        .clk(clk), .reset(reset), .start(t2_start), .current_x(t2_x), .current_y(t2_y),
        .flit_ready(t2_rdy), .flit_valid(t2_vld), .hdr_flg(t2_hdr), .tail_flg(t2_tail),
        .dest_x(t2_dx), .dest_y(t2_dy), .pck_count(t2_cnt), .done(t2_done));

    pck_inject_gen #(.NX(4), .NY(4), .TRAFFIC("RANDOM"), .MAX_PCK_NUM(1000), .PCK_SIZE(4), .INJ_RATE(100)) u_rnd (
        .clk(clk), .reset(reset), .start(r_start), .current_x(2'd0), .current_y(2'd0),
        .flit_ready(1'b1), .flit_valid(r_vld), .hdr_flg(r_hdr), .tail_flg(r_tail),
        .dest_x(r_dx), .dest_y(r_dy), .pck_count(r_cnt), .done(r_done));

    pck_inject_gen #(.NX(8), .NY(4), .TRAFFIC("TORNADO")) u_tor (
        .clk(clk), .reset(reset), .start(to_start), .current_x(3'd6), .current_y(2'd1),
        .flit_ready(1'b1), .flit_valid(to_vld), .hdr_flg(to_hdr), .tail_flg(to_tail),
        .dest_x(to_dx), .dest_y(to_dy), .pck_count(to_cnt), .done(to_done));

    pck_inject_gen #(.NX(8), .NY(4), .TRAFFIC("NEIGHBOR")) u_nb (
        .clk(clk), .reset(reset), .start(nb_start), .current_x(3'd7), .current_y(2'd1),
        .flit_ready(1'b1), .flit_valid(nb_vld), .hdr_flg(nb_hdr), .tail_flg(nb_tail),
        .dest_x(nb_dx), .dest_y(nb_dy), .pck_count(nb_cnt), .done(nb_done));

    logic [5:0] fq[$];   // {hdr, tail, dest_x, dest_y}
    logic [3:0] rq[$];   // {dest_x, dest_y}

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic do_reset();
        t2_start = 1'b0; r_start = 1'b0; to_start = 1'b0; nb_start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({t2_vld, t2_hdr, t2_tail, t2_done} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {t2_vld, t2_hdr, t2_tail, t2_done});
        end
        checks++;
        if ({t2_dx, t2_dy} !== 4'h0) begin
            errors++; $display("FAIL reset_dest: got %h want 0", {t2_dx, t2_dy});
        end
        checks++;
        if (t2_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", t2_cnt);
        end
        reset = 1'b1;
    endtask

    task automatic test_transpose2();
        int  cyc = 0, npk = 0;
        bit  first = 1'b1, prev_tail = 1'b0;
        t2_x = 2'd1; t2_y = 2'd2; t2_rdy = 1'b1;
        do_reset();
        fq.delete();
        for (int p = 0; p < 3; p++)
            for (int f = 0; f < 4; f++)
                fq.push_back({f == 0, f == 3, 2'd2, 2'd1});
        t2_start = 1'b1;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (prev_tail) begin
                checks++;
                if (t2_vld !== 1'b0) begin
                    errors++; $display("FAIL t2_gap_after_tail: flit_valid got %b want 0", t2_vld);
                end
                checks++;
                if (t2_cnt !== 2'(npk)) begin
                    errors++; $display("FAIL t2_pck_count: got %0d want %0d", t2_cnt, npk);
                end
                checks++;
                if (t2_done !== (npk == 3)) begin
                    errors++; $display("FAIL t2_done_timing: got %b want %b after %0d packets", t2_done, npk == 3, npk);
                end
            end
            prev_tail = 1'b0;
            if (t2_vld === 1'b1) begin
                if (first) begin
                    first = 1'b0;
                    checks++;
                    if (cyc != 1) begin
                        errors++; $display("FAIL t2_latency: first flit after %0d cycles want 1", cyc);
                    end
                end
                checks++;
                if (fq.size() == 0) begin
                    errors++; $display("FAIL t2_extra_flit: got flit %b want none", {t2_hdr, t2_tail, t2_dx, t2_dy});
                end else begin
                    logic [5:0] e;
                    e = fq.pop_front();
                    if ({t2_hdr, t2_tail, t2_dx, t2_dy} !== e) begin
                        errors++; $display("FAIL t2_flit: got %b want %b", {t2_hdr, t2_tail, t2_dx, t2_dy}, e);
                    end
                end
                if (t2_tail === 1'b1) begin
                    npk++;
                    prev_tail = 1'b1;
                end
            end
            if (t2_done === 1'b1) break;
        end
        checks++;
        if (fq.size() != 0 || t2_done !== 1'b1) begin
            errors++; $display("FAIL t2_complete: %0d flits missing, done=%b want 0 missing, done=1", fq.size(), t2_done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (t2_vld !== 1'b0 || t2_done !== 1'b1 || t2_cnt !== 2'd3) begin
                errors++; $display("FAIL t2_done_sticky: vld=%b done=%b cnt=%0d want 0 1 3", t2_vld, t2_done, t2_cnt);
            end
        end
    endtask

    task automatic test_no_dest();
        int seen = 0;
        t2_x = 2'd2; t2_y = 2'd2;
        do_reset();
        checks++;
        if (t2_done !== 1'b0) begin
            errors++; $display("FAIL nodest_pre_start: done got %b want 0", t2_done);
        end
        t2_start = 1'b1;
        @(negedge clk);
        checks++;
        if (t2_done !== 1'b1 || t2_vld !== 1'b0) begin
            errors++; $display("FAIL nodest_done: done=%b vld=%b want 1 0", t2_done, t2_vld);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t2_vld === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL nodest_no_flit: flit_valid seen %0d cycles want 0", seen);
        end
    endtask

    task automatic test_backpressure();
        bit got = 1'b0;
        t2_x = 2'd1; t2_y = 2'd2; t2_rdy = 1'b1;
        do_reset();
        t2_start = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (t2_vld === 1'b1 && t2_hdr === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL bp_head_timeout: no head flit want one within 50 cycles");
            return;
        end
        t2_start = 1'b0;
        @(negedge clk);
        t2_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({t2_vld, t2_hdr, t2_tail, t2_dx, t2_dy} !== {3'b100, 2'd2, 2'd1}) begin
                errors++; $display("FAIL bp_hold: got %b want %b", {t2_vld, t2_hdr, t2_tail, t2_dx, t2_dy}, {3'b100, 2'd2, 2'd1});
            end
        end
        t2_rdy = 1'b1;
        fq.delete();
        fq.push_back({2'b00, 2'd2, 2'd1});
        fq.push_back({2'b01, 2'd2, 2'd1});
        for (int i = 0; i < 20 && fq.size() != 0; i++) begin
            @(negedge clk);
            if (t2_vld === 1'b1) begin
                logic [5:0] e;
                e = fq.pop_front();
                checks++;
                if ({t2_hdr, t2_tail, t2_dx, t2_dy} !== e) begin
                    errors++; $display("FAIL bp_resume: got %b want %b", {t2_hdr, t2_tail, t2_dx, t2_dy}, e);
                end
            end
        end
        checks++;
        if (fq.size() != 0) begin
            errors++; $display("FAIL bp_resume_timeout: %0d flits missing want 0", fq.size());
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (t2_vld !== 1'b0 || t2_cnt !== 2'd1 || t2_done !== 1'b0) begin
                errors++; $display("FAIL bp_start_low: vld=%b cnt=%0d done=%b want 0 1 0", t2_vld, t2_cnt, t2_done);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit got = 1'b0;
        t2_x = 2'd1; t2_y = 2'd2; t2_rdy = 1'b1;
        do_reset();
        t2_start = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (t2_vld === 1'b1 && t2_hdr === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL rmid_head_timeout: no head flit want one within 50 cycles");
            return;
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({t2_vld, t2_hdr, t2_tail} !== 3'b100) begin
            errors++; $display("FAIL rmid_flit2: flags got %b want 100", {t2_vld, t2_hdr, t2_tail});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({t2_vld, t2_hdr, t2_tail} !== 3'b000 || t2_cnt !== 2'd0) begin
            errors++; $display("FAIL rmid_abort: flags=%b cnt=%0d want 000 0", {t2_vld, t2_hdr, t2_tail}, t2_cnt);
        end
        reset = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (t2_vld === 1'b1) begin
                got = 1'b1;
                checks++;
                if (t2_hdr !== 1'b1 || t2_cnt !== 2'd0) begin
                    errors++; $display("FAIL rmid_restart: hdr=%b cnt=%0d want 1 0", t2_hdr, t2_cnt);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL rmid_restart_timeout: no flit want one within 50 cycles");
        end
    endtask

    task automatic test_tornado_neighbor();
        bit to_got = 1'b0, nb_got = 1'b0;
        do_reset();
        to_start = 1'b1;
        nb_start = 1'b1;
        for (int i = 0; i < 1000 && !(to_got && nb_got); i++) begin
            @(negedge clk);
            if (!to_got && to_vld === 1'b1 && to_hdr === 1'b1) begin
                to_got = 1'b1;
                checks++;
                if ({to_dx, to_dy} !== {3'd1, 2'd1}) begin
                    errors++; $display("FAIL tornado_dest: got (%0d,%0d) want (1,1)", to_dx, to_dy);
                end
            end
            if (!nb_got && nb_vld === 1'b1 && nb_hdr === 1'b1) begin
                nb_got = 1'b1;
                checks++;
                if ({nb_dx, nb_dy} !== {3'd0, 2'd1}) begin
                    errors++; $display("FAIL neighbor_dest: got (%0d,%0d) want (0,1)", nb_dx, nb_dy);
                end
            end
        end
        checks++;
        if (!(to_got && nb_got)) begin
            errors++; $display("FAIL pattern_timeout: tornado=%b neighbor=%b want both 1", to_got, nb_got);
        end
        to_start = 1'b0;
        nb_start = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] m_lfsr;
        int          m_state = 0;   // 0 idle, 1 send, 2 done
        int          m_flit = 0, m_cnt = 0, tail_wait = 0, vld_err = 0, n_seen = 0;
        bit          seen[16];
        bit          finished = 1'b0;
        do_reset();
        foreach (seen[i]) seen[i] = 1'b0;
        rq.delete();
        m_lfsr  = 16'hACE1;
        r_start = 1'b1;
        for (int cyc = 0; cyc < 15000 && !finished; cyc++) begin
            checks++;
            if (r_vld !== (m_state == 1)) begin
                errors++;
                vld_err++;
                if (vld_err <= 10) $display("FAIL rnd_valid: cycle %0d got %b want %b", cyc, r_vld, m_state == 1);
            end
            if (r_vld === 1'b1 && r_hdr === 1'b1) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_head: got (%0d,%0d) want none", r_dx, r_dy);
                end else begin
                    logic [3:0] e;
                    e = rq.pop_front();
                    if ({r_dx, r_dy} !== e) begin
                        errors++; $display("FAIL rnd_dest: got (%0d,%0d) want (%0d,%0d)", r_dx, r_dy, e[3:2], e[1:0]);
                    end
                end
                seen[{r_dy, r_dx}] = 1'b1;
            end
            case (m_state)
                0: if ((m_lfsr % 16'd100) < 16'd100) begin
                    int dd;
                    dd = int'(m_lfsr % 16'd16);
                    if (dd != 0) begin
                        rq.push_back({2'(dd % 4), 2'(dd / 4)});
                        m_state = 1;
                        m_flit  = 0;
                    end
                end
                1: if (m_flit == 3) begin
                    m_cnt++;
                    m_state = (m_cnt == 1000) ? 2 : 0;
                end else begin
                    m_flit++;
                end
                default: begin
                    tail_wait++;
                    if (tail_wait > 3) finished = 1'b1;
                end
            endcase
            m_lfsr = lfsr_step(m_lfsr);
            @(negedge clk);
        end
        for (int i = 1; i < 16; i++) if (seen[i]) n_seen++;
        checks++;
        if (!finished) begin
            errors++; $display("FAIL rnd_timeout: %0d packets modelled want 1000", m_cnt);
        end
        checks++;
        if (seen[0]) begin
            errors++; $display("FAIL rnd_self_dest: own node seen as destination want never");
        end
        checks++;
        if (n_seen != 15) begin
            errors++; $display("FAIL rnd_coverage: %0d destinations seen want 15", n_seen);
        end
        checks++;
        if (r_cnt !== 10'd1000 || r_done !== 1'b1 || r_vld !== 1'b0) begin
            errors++; $display("FAIL rnd_final: cnt=%0d done=%b vld=%b want 1000 1 0", r_cnt, r_done, r_vld);
        end
        checks++;
        if (rq.size() != 0) begin
            errors++; $display("FAIL rnd_missing_heads: %0d left want 0", rq.size());
        end
        r_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_transpose2();
        test_no_dest();
        test_backpressure();
        test_reset_mid_packet();
        test_tornado_neighbor();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
